// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (I) and load/store (D).
// One transaction in flight; watchdog aborts a stalled WAIT after TIMEOUT cycles.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam int            CW    = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO    = CW'(TIMEOUT);
  localparam bit            WD_EN = (TIMEOUT != 0);

  state_e        state_q, state_d;
  logic          own_d_q, own_d_d;     // current owner is the D port
  logic          prio_i_q, prio_i_d;   // I wins the next tie
  logic [CW-1:0] cnt_q, cnt_d;
  logic          i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic          i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [31:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          busy_q, busy_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_wmask_q, mem_wmask_d;
  logic          pick_d;
  logic          finish;
  logic [31:0]   rsp_data;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    own_d_d     = own_d_q;
    prio_i_d    = prio_i_q;
    cnt_d       = cnt_q;
    i_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    i_rvalid_d  = 1'b0;
    d_rvalid_d  = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_req_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    pick_d      = d_req && (!i_req || !prio_i_q);
    finish      = 1'b0;
    rsp_data    = 32'd0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d     = ISSUE;
          own_d_d     = pick_d;
          mem_addr_d  = pick_d ? d_addr  : i_addr;
          mem_wdata_d = pick_d ? d_wdata : 32'd0;
          mem_wmask_d = pick_d ? d_wmask : 4'd0;
          mem_req_d   = 1'b1;
          i_gnt_d     = !pick_d;
          d_gnt_d     = pick_d;
        end
      end
      ISSUE: begin
        // mem_done here would be a protocol violation, so it is not looked at
        state_d  = WAIT;
        cnt_d    = '0;
        prio_i_d = own_d_q;
      end
      WAIT: begin
        if (WD_EN) cnt_d = cnt_inc;
        if (mem_done) begin
          finish    = 1'b1;
          rsp_data  = (mem_wmask_q == 4'd0) ? mem_rdata : 32'd0;
          rsp_err_d = 1'b0;
        end else if (WD_EN && cnt_inc == TO) begin
          finish    = 1'b1;
          rsp_err_d = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = RESP;
      if (own_d_q) begin
        d_rvalid_d = 1'b1;
        d_rdata_d  = rsp_data;
      end else begin
        i_rvalid_d = 1'b1;
        i_rdata_d  = rsp_data;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      own_d_q     <= 1'b0;
      prio_i_q    <= 1'b1;
      cnt_q       <= '0;
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      i_rdata_q   <= 32'd0;
      d_rdata_q   <= 32'd0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wmask_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      own_d_q     <= own_d_d;
      prio_i_q    <= prio_i_d;
      cnt_q       <= cnt_d;
      i_gnt_q     <= i_gnt_d;
      d_gnt_q     <= d_gnt_d;
      i_rvalid_q  <= i_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
    end
  end

  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign i_rvalid  = i_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4): fetch, store, contention, watchdog, resets.
module tb_mem_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, d_req, mem_done;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_wmask;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, rsp_err, busy, mem_req;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Waits for a grant, checks the issue, serves memory, checks the response.
  // done_at: WAIT cycle index carrying mem_done, -1 for never.
  task automatic run_txn(input string tag, input bit exp_d, input bit drop,
                         input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] em,
                         input int done_at, input logic [31:0] rd,
                         input logic exp_err, input logic [31:0] er);
    int n = 0;
    int nw;
    while (!(i_gnt || d_gnt) && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!(i_gnt || d_gnt)) begin
      chk({tag, "_gnt_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, "_d_gnt"}, d_gnt, exp_d);
    chk({tag, "_i_gnt"}, i_gnt, !exp_d);
    chk({tag, "_mem_req"}, mem_req, 1);
    chk({tag, "_mem_addr"}, mem_addr, ea);
    chk({tag, "_mem_wdata"}, mem_wdata, ew);
    chk({tag, "_mem_wmask"}, mem_wmask, em);
    chk({tag, "_busy_iss"}, busy, 1);
    if (drop) begin
      if (exp_d) d_req = 1'b0;
      else i_req = 1'b0;
    end
    nw = (done_at >= 0) ? done_at + 1 : TO;
    for (int k = 0; k < nw; k++) begin
      @(negedge clk);
      if (k == 0) chk({tag, "_req_pulse"}, {mem_req, i_gnt, d_gnt}, 0);
      mem_done  = (k == done_at);
      mem_rdata = rd;
    end
    @(negedge clk);
    mem_done = 1'b0;
    chk({tag, "_i_rvalid"}, i_rvalid, !exp_d);
    chk({tag, "_d_rvalid"}, d_rvalid, exp_d);
    chk({tag, "_rdata"}, exp_d ? d_rdata : i_rdata, er);
    chk({tag, "_rsp_err"}, rsp_err, exp_err);
    @(negedge clk);
    chk({tag, "_idle"}, {busy, i_rvalid, d_rvalid, i_gnt, d_gnt}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got 0 exp 1");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    resetn = 1'b0; i_req = 0; d_req = 0; mem_done = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_wmask = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {busy, i_gnt, d_gnt, i_rvalid, d_rvalid, mem_req, rsp_err}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    resetn = 1'b1;

    i_req = 1; i_addr = 32'h8;
    run_txn("fetch", 0, 1, 32'h8, 0, 0, 0, 32'h00A08093, 0, 32'h00A08093);

    d_req = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_wmask = 4'b0011;
    run_txn("store", 1, 1, 32'h40, 32'hDEADBEEF, 4'b0011, 0, 32'hFFFFFFFF, 0, 0);

    i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h200; d_wdata = 32'h55; d_wmask = 0;
    run_txn("cont0", 0, 0, 32'h100, 0, 0, 1, 32'h11, 0, 32'h11);
    run_txn("cont1", 1, 0, 32'h200, 32'h55, 0, 0, 32'h22, 0, 32'h22);
    run_txn("cont2", 0, 0, 32'h100, 0, 0, 2, 32'h33, 0, 32'h33);
    i_req = 0; d_req = 0;

    // pointer now favours D; a reset must bring it back to I
    resetn = 0; @(negedge clk); resetn = 1;
    i_req = 1; d_req = 1;
    run_txn("rprio_i", 0, 1, 32'h100, 0, 0, 0, 32'h44, 0, 32'h44);
    run_txn("rprio_d", 1, 1, 32'h200, 32'h55, 0, 0, 32'h66, 0, 32'h66);

    i_req = 1; i_addr = 32'h300;
    run_txn("wdog", 0, 1, 32'h300, 0, 0, -1, 32'hBAD, 1, 0);
    i_req = 1; i_addr = 32'h304;
    run_txn("wdog_edge", 0, 1, 32'h304, 0, 0, TO - 1, 32'h77, 0, 32'h77);

    d_req = 1; d_addr = 32'h400; d_wmask = 0;
    n = 0;
    while (!d_gnt && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("mid_d_gnt", d_gnt, 1);
    d_req = 0;
    repeat (2) @(negedge clk);
    resetn = 0; @(negedge clk); resetn = 1;
    chk("mid_ctl", {busy, d_rvalid, i_rvalid, mem_req, rsp_err, d_gnt, i_gnt}, 0);
    chk("mid_mem_addr", mem_addr, 0);
    chk("mid_i_rdata", i_rdata, 0);
    chk("mid_d_rdata", d_rdata, 0);
    mem_done = 1; mem_rdata = 32'h99;
    @(negedge clk);
    mem_done = 0;
    chk("late_done0", {busy, d_rvalid, i_rvalid}, 0);
    @(negedge clk);
    chk("late_done1", {busy, d_rvalid, i_rvalid, d_rdata[0]}, 0);

    i_req = 1; d_req = 1; i_addr = 32'h500; d_addr = 32'h600;
    run_txn("post_i", 0, 1, 32'h500, 0, 0, 0, 32'hA5, 0, 32'hA5);
    run_txn("post_d", 1, 1, 32'h600, 32'h55, 0, 1, 32'h5A, 0, 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
